// File: rtl/sass_pkg.sv
// Shared soundpath types and default sizes for the keypad-to-voice path.
package sass_pkg;

  localparam int unsigned NOTE_W         = 4;
  localparam int unsigned KEY_IDX_W      = 4;
  localparam int unsigned NUM_VOICES_DEF = 4;
  localparam int unsigned NUM_KEYS_DEF   = 13;

  typedef logic [NOTE_W-1:0] note_t;

  localparam note_t NOTE_SILENT = 4'd0;

endpackage

// File: rtl/voice_allocator_if.sv
// Keypad/sequencer inputs and per-voice note outputs of the voice allocator.
interface voice_allocator_if
  import sass_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned NUM_KEYS   = NUM_KEYS_DEF
) ();

  logic [NUM_KEYS-1:0]          key_down;
  logic                         seq_on;
  note_t                        seq_note;
  logic [NOTE_W*NUM_VOICES-1:0] voice_note;
  logic [NUM_VOICES-1:0]        voice_active;
  logic [2:0]                   active_count;
  logic                         steal_pulse;

  modport master (
    output key_down, seq_on, seq_note,
    input  voice_note, voice_active, active_count, steal_pulse
  );

  modport slave (
    input  key_down, seq_on, seq_note,
    output voice_note, voice_active, active_count, steal_pulse
  );

endinterface

// File: rtl/voice_allocator_voice_pick.sv
// Target voice selection: lowest free voice, else the oldest eligible voice
// (ties to the lowest index), flagged as a steal.
module voice_pick #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AW         = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]    free_i,
  input  logic [NUM_VOICES-1:0]    elig_i,
  input  logic [NUM_VOICES*AW-1:0] age_i,
  output logic [AW-1:0]            idx_o,
  output logic                     found_o,
  output logic                     steal_o
);

  logic          any_free;
  logic [AW-1:0] best_age;

  always_comb begin
    idx_o    = '0;
    found_o  = 1'b0;
    steal_o  = 1'b0;
    any_free = 1'b0;
    best_age = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (free_i[v] && !any_free) begin
        any_free = 1'b1;
        idx_o    = AW'(v);
      end
    end
    if (any_free) begin
      found_o = 1'b1;
    end else begin
      // strict compare keeps the lowest index among equal ages
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (elig_i[v] && (!steal_o || (age_i[v*AW +: AW] > best_age))) begin
          steal_o  = 1'b1;
          best_age = age_i[v*AW +: AW];
          idx_o    = AW'(v);
        end
      end
      found_o = steal_o;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: key-to-voice ownership, one allocation per cycle.
// Optional oldest-voice stealing is built when VOICE_STEAL_EN is defined.
module voice_allocator
  import sass_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned NUM_KEYS   = NUM_KEYS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  voice_allocator_if.slave bus
);

  localparam int unsigned   AW      = $clog2(NUM_VOICES);
  localparam int unsigned   KW      = KEY_IDX_W;
  localparam logic [AW-1:0] AGE_MAX = AW'(NUM_VOICES - 1);

  logic [NUM_VOICES-1:0]        vact_q, vact_r, vact_d, act_d;
  logic [KW-1:0]                vkey_q [NUM_VOICES];
  logic [KW-1:0]                vkey_d [NUM_VOICES];
  logic [AW-1:0]                vage_q [NUM_VOICES];
  logic [AW-1:0]                vage_d [NUM_VOICES];
  logic [NUM_KEYS-1:0]          asg_q, asg_r, asg_d;
  logic [NUM_KEYS-1:0]          dead_c, pend_c;
  logic [NUM_VOICES-1:0]        seq_mask, free_c, elig_c;
  logic [NUM_VOICES*AW-1:0]     age_flat;
  logic                         pend_any;
  logic [KW-1:0]                pend_idx;
  logic [AW-1:0]                pick_idx;
  logic                         pick_found, pick_steal;
  logic [NOTE_W*NUM_VOICES-1:0] note_d, note_q;
  logic [NUM_VOICES-1:0]        active_q;
  logic [3:0]                   cnt_c;
  logic [2:0]                   count_d, count_q;
`ifdef VOICE_STEAL_EN
  logic [NUM_KEYS-1:0]          dead_q, dead_r, dead_d;
  logic                         steal_d, steal_q;
`endif

  // Release stage: drop voices whose key is up, then hand voice 0 to the sequencer
  always_comb begin
    vact_r = vact_q;
    asg_r  = asg_q & bus.key_down;
`ifdef VOICE_STEAL_EN
    dead_r = dead_q & bus.key_down;
`endif
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if ((KW'(k) == vkey_q[v]) && !bus.key_down[k]) vact_r[v] = 1'b0;
      end
    end
    if (bus.seq_on && vact_r[0]) begin
      vact_r[0] = 1'b0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (KW'(k) == vkey_q[0]) begin
          asg_r[k] = 1'b0;
`ifdef VOICE_STEAL_EN
          dead_r[k] = 1'b1;
`endif
        end
      end
    end
  end

`ifdef VOICE_STEAL_EN
  assign dead_c = dead_r;
  assign elig_c = vact_r & ~seq_mask;
`else
  assign dead_c = '0;
  assign elig_c = '0;
`endif

  assign seq_mask = NUM_VOICES'(bus.seq_on);
  assign free_c   = ~vact_r & ~seq_mask;
  assign pend_c   = bus.key_down & ~asg_r & ~dead_c;

  always_comb begin
    pend_any = 1'b0;
    pend_idx = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (pend_c[k] && !pend_any) begin
        pend_any = 1'b1;
        pend_idx = KW'(k);
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_age
    assign age_flat[g*AW +: AW] = vage_q[g];
  end

  voice_pick #(
    .NUM_VOICES (NUM_VOICES),
    .AW         (AW)
  ) u_pick (
    .free_i  (free_c),
    .elig_i  (elig_c),
    .age_i   (age_flat),
    .idx_o   (pick_idx),
    .found_o (pick_found),
    .steal_o (pick_steal)
  );

  // Allocation stage: at most one pending key takes the picked voice
  always_comb begin
    vact_d = vact_r;
    vkey_d = vkey_q;
    vage_d = vage_q;
    asg_d  = asg_r;
`ifdef VOICE_STEAL_EN
    dead_d  = dead_r;
    steal_d = 1'b0;
`endif
    if (pend_any && pick_found) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (vact_r[v] && (AW'(v) != pick_idx) && (vage_q[v] != AGE_MAX))
          vage_d[v] = vage_q[v] + AW'(1);
      end
      if (pick_steal) begin
`ifdef VOICE_STEAL_EN
        steal_d = 1'b1;
`endif
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if ((AW'(v) == pick_idx) && (KW'(k) == vkey_q[v])) begin
              asg_d[k] = 1'b0;
`ifdef VOICE_STEAL_EN
              dead_d[k] = 1'b1;
`endif
            end
          end
        end
      end
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (AW'(v) == pick_idx) begin
          vact_d[v] = 1'b1;
          vkey_d[v] = pend_idx;
          vage_d[v] = '0;
        end
      end
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (KW'(k) == pend_idx) asg_d[k] = 1'b1;
      end
    end
  end

  // Output images are built from next state so a press shows on the next edge
  always_comb begin
    note_d = {NUM_VOICES{NOTE_SILENT}};
    act_d  = vact_d | seq_mask;
    cnt_c  = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (vact_d[v]) note_d[v*NOTE_W +: NOTE_W] = NOTE_W'(vkey_d[v] + KW'(1));
      cnt_c = cnt_c + 4'(act_d[v]);
    end
    if (bus.seq_on) note_d[NOTE_W-1:0] = bus.seq_note;
    count_d = cnt_c[3] ? 3'd7 : cnt_c[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vact_q   <= '0;
      asg_q    <= '0;
      note_q   <= '0;
      active_q <= '0;
      count_q  <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        vkey_q[v] <= '0;
        vage_q[v] <= '0;
      end
    end else begin
      vact_q   <= vact_d;
      asg_q    <= asg_d;
      note_q   <= note_d;
      active_q <= act_d;
      count_q  <= count_d;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        vkey_q[v] <= vkey_d[v];
        vage_q[v] <= vage_d[v];
      end
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dead_q  <= '0;
      steal_q <= 1'b0;
    end else begin
      dead_q  <= dead_d;
      steal_q <= steal_d;
    end
  end

  assign bus.steal_pulse = steal_q;
`else
  assign bus.steal_pulse = 1'b0;
`endif

  assign bus.voice_note   = note_q;
  assign bus.voice_active = active_q;
  assign bus.active_count = count_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed plus random stimulus for voice_allocator against a key/voice ownership model.
module tb_voice_allocator;
  import sass_pkg::*;

  localparam int unsigned NV = NUM_VOICES_DEF;
  localparam int unsigned NK = NUM_KEYS_DEF;
`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  voice_allocator_if #(.NUM_VOICES(NV), .NUM_KEYS(NK)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .NUM_KEYS(NK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: who owns each voice, and the allocation serial number it got
  bit  m_act   [NV];
  int  m_key   [NV];
  int  m_stamp [NV];
  bit  m_asg   [NK];
  bit  m_dead  [NK];
  int  m_ctr;

  logic [4*NV-1:0] e_note;
  logic [NV-1:0]   e_act;
  logic [2:0]      e_cnt;
  logic            e_pulse;
  logic [NK-1:0]   kd_r;

  int errors;
  int checks;

  function automatic int age_of(input int v);
    int a;
    a = m_ctr - m_stamp[v];
    return (a > int'(NV) - 1) ? int'(NV) - 1 : a;
  endfunction

  task automatic model_edge();
    logic [NK-1:0] kd;
    bit seq;
    int pk, tgt, best, cnt;
    kd      = bus.key_down;
    seq     = bus.seq_on;
    e_pulse = 1'b0;
    if (rst) begin
      for (int v = 0; v < int'(NV); v++) begin m_act[v] = 0; m_key[v] = 0; m_stamp[v] = 0; end
      for (int k = 0; k < int'(NK); k++) begin m_asg[k] = 0; m_dead[k] = 0; end
      m_ctr = 0;
    end else begin
      for (int v = 0; v < int'(NV); v++)
        if (m_act[v] && !kd[m_key[v]]) begin m_act[v] = 0; m_asg[m_key[v]] = 0; end
      for (int k = 0; k < int'(NK); k++)
        if (!kd[k]) m_dead[k] = 0;
      if (seq && m_act[0]) begin
        m_act[0] = 0;
        m_asg[m_key[0]] = 0;
        if (STEAL) m_dead[m_key[0]] = 1;
      end
      pk = -1;
      for (int k = 0; k < int'(NK); k++)
        if (pk < 0 && kd[k] && !m_asg[k] && !m_dead[k]) pk = k;
      tgt = -1;
      for (int v = 0; v < int'(NV); v++)
        if (tgt < 0 && !m_act[v] && !(seq && v == 0)) tgt = v;
      if (tgt < 0 && STEAL) begin
        best = -1;
        for (int v = 0; v < int'(NV); v++)
          if (m_act[v] && !(seq && v == 0) && age_of(v) > best) begin best = age_of(v); tgt = v; end
      end
      if (pk >= 0 && tgt >= 0) begin
        if (m_act[tgt]) begin
          m_asg[m_key[tgt]]  = 0;
          m_dead[m_key[tgt]] = 1;
          e_pulse = 1'b1;
        end
        m_ctr++;
        m_act[tgt]   = 1;
        m_key[tgt]   = pk;
        m_stamp[tgt] = m_ctr;
        m_asg[pk]    = 1;
      end
    end
    e_note = '0;
    e_act  = '0;
    cnt    = 0;
    if (!rst) begin
      for (int v = 0; v < int'(NV); v++)
        if (m_act[v]) begin e_note[v*4 +: 4] = 4'(m_key[v] + 1); e_act[v] = 1'b1; end
      if (seq) begin e_note[3:0] = bus.seq_note; e_act[0] = 1'b1; end
    end
    for (int v = 0; v < int'(NV); v++) cnt += int'(e_act[v]);
    e_cnt = (cnt > 7) ? 3'd7 : 3'(cnt);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".note"},   32'(bus.voice_note),   32'(e_note));
    chk({tag, ".active"}, 32'(bus.voice_active), 32'(e_act));
    chk({tag, ".count"},  32'(bus.active_count), 32'(e_cnt));
    chk({tag, ".pulse"},  32'(bus.steal_pulse),  32'(e_pulse));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_ctr  = 0;
    rst          = 1'b1;
    bus.key_down = '0;
    bus.seq_on   = 1'b0;
    bus.seq_note = '0;
    step("reset");
    chk("reset_zero", 32'(bus.voice_note), 32'h0);
    rst = 1'b0;

    bus.key_down[4] = 1'b1;
    step("press4");
    chk("press4_v0", 32'(bus.voice_note[3:0]), 32'd5);
    chk("press4_act", 32'(bus.voice_active), 32'b0001);
    chk("press4_cnt", 32'(bus.active_count), 32'd1);
    bus.key_down[4] = 1'b0;
    step("rel4");
    chk("rel4_silent", 32'(bus.voice_note), 32'h0);

    kd_r = '0;
    kd_r[0] = 1'b1; kd_r[2] = 1'b1; kd_r[7] = 1'b1;
    bus.key_down = kd_r;
    for (int i = 0; i < 3; i++) begin
      step("chord");
      chk("chord_cnt", 32'(bus.active_count), 32'(i + 1));
    end
    chk("chord_notes", 32'(bus.voice_note), 32'h0831);
    bus.key_down = '0;
    step("chord_rel");

    for (int i = 0; i < 4; i++) begin
      bus.key_down[i] = 1'b1;
      step("hold");
    end
    chk("hold_notes", 32'(bus.voice_note), 32'h4321);
    bus.key_down[9] = 1'b1;
    step("k9");
`ifdef VOICE_STEAL_EN
    chk("steal_note", 32'(bus.voice_note), 32'h432A);
    chk("steal_pulse", 32'(bus.steal_pulse), 32'd1);
    step("after_steal");
    chk("steal_once", 32'(bus.steal_pulse), 32'd0);
    chk("key0_silent", 32'(bus.voice_note), 32'h432A);
    bus.key_down[0] = 1'b0;
    step("k0_up");
    bus.key_down[0] = 1'b1;
    step("k0_repress");
    chk("k0_back", 32'(bus.voice_note), 32'h431A);
`else
    chk("nosteal_hold", 32'(bus.voice_note), 32'h4321);
    chk("nosteal_pulse", 32'(bus.steal_pulse), 32'd0);
    bus.key_down[2] = 1'b0;
    step("k2_up");
    chk("nosteal_k9", 32'(bus.voice_note), 32'h4A21);
`endif
    bus.key_down = '0;
    step("hold_rel");

    bus.key_down[5] = 1'b1;
    step("k5");
    chk("k5_v0", 32'(bus.voice_note[3:0]), 32'd6);
    bus.seq_on   = 1'b1;
    bus.seq_note = 4'd7;
    step("seq_up");
    chk("seq_v0", 32'(bus.voice_note[3:0]), 32'd7);
    chk("seq_act0", 32'(bus.voice_active[0]), 32'd1);
    bus.key_down[8] = 1'b1;
    step("seq_press");
    chk("seq_keep_v0", 32'(bus.voice_note[3:0]), 32'd7);
`ifdef VOICE_STEAL_EN
    chk("seq_press_v1", 32'(bus.voice_note[7:4]), 32'd9);
`endif
    bus.seq_on = 1'b0;
    step("seq_down");
    bus.key_down[10] = 1'b1;
    step("after_seq");
    chk("v0_reused", 32'(bus.voice_note[3:0]), 32'hB);
    bus.key_down = '0;
    step("seq_rel");

    bus.key_down = NK'(4'hF);
    for (int i = 0; i < 4; i++) step("full");
    chk("full_notes", 32'(bus.voice_note), 32'h4321);
    bus.key_down[3]  = 1'b0;
    bus.key_down[11] = 1'b1;
    step("swap");
    chk("swap_notes", 32'(bus.voice_note), 32'hC321);
    chk("swap_nosteal", 32'(bus.steal_pulse), 32'd0);
    bus.key_down = '0;
    step("swap_rel");

    kd_r = '0;
    kd_r[1] = 1'b1; kd_r[6] = 1'b1; kd_r[8] = 1'b1;
    bus.key_down = kd_r;
    for (int i = 0; i < 3; i++) step("pre_rst");
    chk("pre_rst_notes", 32'(bus.voice_note), 32'h0972);
    kd_r[8] = 1'b0;
    bus.key_down = kd_r;
    rst = 1'b1;
    step("mid_rst");
    chk("mid_rst_zero", 32'(bus.voice_active), 32'h0);
    rst = 1'b0;
    step("post_rst1");
    chk("post_rst1", 32'(bus.voice_note), 32'h0002);
    step("post_rst2");
    chk("post_rst2", 32'(bus.voice_note), 32'h0072);

    for (int n = 0; n < 400; n++) begin
      kd_r = bus.key_down;
      for (int k = 0; k < int'(NK); k++)
        if ($urandom_range(0, 5) == 0) kd_r[k] = ~kd_r[k];
      bus.key_down = kd_r;
      if ($urandom_range(0, 24) == 0) bus.seq_on = ~bus.seq_on;
      bus.seq_note = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 99) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
